// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: command opcodes, FSM states, flag layout, ALU opcodes.
// ALU_SEQ_CMP_EN decides whether command 110 (CMP) is routed to the ALU or rejected as reserved.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_LDI = 3'b100,
    OP_RD  = 3'b101,
    OP_CMP = 3'b110,
    OP_RSV = 3'b111
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ISSUE   = 2'b01,
    S_CAPTURE = 2'b10,
    S_RESP    = 2'b11
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } flags_t;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  function automatic logic is_alu_op(input cmd_op_e op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
`ifdef ALU_SEQ_CMP_EN
      OP_CMP:                        return 1'b1;
`endif
      default:                       return 1'b0;
    endcase
  endfunction

  // CMP borrows the subtractor; every other ALU command maps straight onto its low bits.
  function automatic logic [1:0] alu_opcode_of(input cmd_op_e op);
    logic [2:0] w_raw;
    w_raw = op;
    return (op == OP_CMP) ? ALU_SUB : w_raw[1:0];
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command and response channels between the front-end (master) and the sequencer (slave).
// Both directions use valid/ready; a beat transfers when valid and ready are high at a clock edge.
interface alu_seq_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [RW-1:0]    cmd_rd;
  logic [RW-1:0]    cmd_rs1;
  logic [RW-1:0]    cmd_rs2;
  logic [WIDTH-1:0] cmd_imm;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       rsp_flags;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
  );

endinterface

// File: rtl/alu_seq_regfile.sv
// NREGS x WIDTH register file: two asynchronous read ports and one synchronous write port.
// A write lands at the clock edge it is presented on; all entries clear on reset.
module alu_seq_regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int RW    = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_we,
  input  logic [RW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [RW-1:0]    i_raddr_a,
  output logic [WIDTH-1:0] o_rdata_a,
  input  logic [RW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_b
);

  logic [WIDTH-1:0] r_mem [NREGS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Runs one register-level command at a time through an external ALU whose flags lag its result by a clock.
// ALU ops respond 3 cycles after accept, LDI/RD/reserved after 1; op 110 is CMP only with ALU_SEQ_CMP_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int RW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  alu_seq_if.slave         cmd_if,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow
);

  state_e           r_state;
  state_e           w_state_nxt;
  cmd_op_e          w_op;
  logic             w_accept;
  logic             w_issue;

  logic             w_we;
  logic [RW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rdata_a;
  logic [WIDTH-1:0] w_rdata_b;

  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_op;
  logic [RW-1:0]    r_rd;
  logic             r_wb;
  flags_t           r_flags;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;

  assign w_op    = cmd_op_e'(cmd_if.cmd_op);
  assign w_issue = is_alu_op(w_op);

  alu_seq_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .RW    (RW)
  ) u_regfile (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (cmd_if.cmd_rs1),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (cmd_if.cmd_rs2),
    .o_rdata_b (w_rdata_b)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The write port is shared: LDI writes at accept, ALU ops write back from CAPTURE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_we        = 1'b0;
    w_waddr     = r_rd;
    w_wdata     = alu_result;
    case (r_state)
      S_IDLE: begin
        w_accept = cmd_if.cmd_valid;
        if (cmd_if.cmd_valid) begin
          w_state_nxt = w_issue ? S_ISSUE : S_RESP;
          if (w_op == OP_LDI) begin
            w_we    = 1'b1;
            w_waddr = cmd_if.cmd_rd;
            w_wdata = cmd_if.cmd_imm;
          end
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_state_nxt = S_RESP;
        w_we        = r_wb;
      end
      S_RESP: begin
        if (cmd_if.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operands are loaded at accept so the ALU sees them for the whole ISSUE cycle and its
  // flags are registered at the end of it; they then hold until the next ALU command.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_rd        <= '0;
      r_wb        <= 1'b0;
      r_flags     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rd <= cmd_if.cmd_rd;
            r_wb <= (w_op != OP_CMP);
            if (w_issue) begin
              r_alu_a  <= w_rdata_a;
              r_alu_b  <= w_rdata_b;
              r_alu_op <= alu_opcode_of(w_op);
            end else begin
              r_rsp_valid <= 1'b1;
              case (w_op)
                OP_LDI: begin
                  r_rsp_data <= cmd_if.cmd_imm;
                  r_rsp_err  <= 1'b0;
                end
                OP_RD: begin
                  r_rsp_data <= w_rdata_a;
                  r_rsp_err  <= 1'b0;
                end
                default: begin
                  r_rsp_data <= '0;
                  r_rsp_err  <= 1'b1;
                end
              endcase
            end
          end
        end
        S_CAPTURE: begin
          r_flags     <= '{zero: alu_zero, carry: alu_carry, overflow: alu_overflow};
          r_rsp_data  <= alu_result;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
        end
        S_RESP: begin
          if (cmd_if.rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_a            = r_alu_a;
  assign alu_b            = r_alu_b;
  assign alu_opcode       = r_alu_op;
  assign cmd_if.cmd_ready = (r_state == S_IDLE);
  assign cmd_if.rsp_valid = r_rsp_valid;
  assign cmd_if.rsp_data  = r_rsp_data;
  assign cmd_if.rsp_flags = r_flags;
  assign cmd_if.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a stand-in ALU, an arithmetic reference model fed at accept time,
// and a monitor that pops expectations, checks latency and holds rsp_ready low to test stalls.
`timescale 1ns/1ps
module tb_alu_sequencer;

  localparam int WIDTH = 8;
  localparam int NREGS = 4;

  typedef struct {
    logic [7:0] data;
    logic [2:0] flags;
    logic       err;
    int         acc;
    int         lat;
    int         stall;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  alu_seq_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

  logic [7:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_opcode;
  logic       alu_zero, alu_carry, alu_overflow;

  alu_sequencer #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cmd_if       (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow)
  );

  // Plain-arithmetic ALU: 00 AND, 01 OR, 10 ADD, 11 SUB; carry on SUB means borrow.
  function automatic logic [7:0] alu_res(input logic [1:0] opc, input logic [7:0] a, input logic [7:0] b);
    case (opc)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return 8'(int'(a) + int'(b));
      default: return 8'(int'(a) - int'(b));
    endcase
  endfunction

  function automatic logic [2:0] alu_flg(input logic [1:0] opc, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, r;
    logic c, v;
    sa = $signed(a);
    sb = $signed(b);
    c = 1'b0;
    v = 1'b0;
    if (opc == 2'b10) begin
      c = (int'(a) + int'(b)) > 255;
      r = sa + sb;
      v = (r > 127) || (r < -128);
    end else if (opc == 2'b11) begin
      c = int'(a) < int'(b);
      r = sa - sb;
      v = (r > 127) || (r < -128);
    end
    return {alu_res(opc, a, b) == 8'h00, c, v};
  endfunction

  always_comb alu_result = alu_res(alu_opcode, alu_a, alu_b);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) {alu_zero, alu_carry, alu_overflow} <= 3'b000;
    else          {alu_zero, alu_carry, alu_overflow} <= alu_flg(alu_opcode, alu_a, alu_b);
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  bit   mon_have = 1'b0;

  logic [7:0] m_regs [NREGS];
  logic [2:0] m_flags;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_flags = 3'b000;
  endfunction

  // Reference model applied in acceptance order; returns the response this command must produce.
  function automatic exp_t predict(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                   input logic [1:0] rs2, input logic [7:0] imm);
    exp_t e;
    logic [7:0] a, b;
    a = m_regs[rs1];
    b = m_regs[rs2];
    e.data = 8'h00; e.err = 1'b0; e.lat = 1; e.acc = 0; e.stall = 0;
    case (op)
      3'b000, 3'b001, 3'b010, 3'b011: begin
        e.data     = alu_res(op[1:0], a, b);
        m_flags    = alu_flg(op[1:0], a, b);
        m_regs[rd] = e.data;
        e.lat      = 3;
      end
      3'b100: begin
        m_regs[rd] = imm;
        e.data     = imm;
      end
      3'b101: e.data = a;
`ifdef ALU_SEQ_CMP_EN
      3'b110: begin
        e.data  = alu_res(2'b11, a, b);
        m_flags = alu_flg(2'b11, a, b);
        e.lat   = 3;
      end
`endif
      default: e.err = 1'b1;
    endcase
    e.flags = m_flags;
    return e;
  endfunction

  task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic [7:0] imm, input int stall);
    exp_t e;
    int n;
    n = 0;
    @(negedge clock);
    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_imm = imm;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.cmd_ready) begin
      chk("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    e = predict(op, rd, rs1, rs2, imm);
    e.acc = cyc;
    e.stall = stall;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op  = 3'($urandom); bus.cmd_rd = 2'($urandom); bus.cmd_rs1 = 2'($urandom);
    bus.cmd_rs2 = 2'($urandom); bus.cmd_imm = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_have) && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0 || mon_have) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor/responder: pops on the first cycle rsp_valid is seen, then checks hold during stalls.
  initial begin
    exp_t cur;
    int   stall;
    stall = 0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        mon_have = 1'b0;
        bus.rsp_ready = 1'b0;
      end else if (mon_have || bus.rsp_valid) begin
        if (!mon_have) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            bus.rsp_ready = 1'b1;
            continue;
          end
          cur = exp_q.pop_front();
          mon_have = 1'b1;
          stall = cur.stall;
          chk("rsp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
        end else begin
          chk("rsp_valid_hold", 32'(bus.rsp_valid), 32'd1);
        end
        chk("rsp_data",  32'(bus.rsp_data),  32'(cur.data));
        chk("rsp_flags", 32'(bus.rsp_flags), 32'(cur.flags));
        chk("rsp_err",   32'(bus.rsp_err),   32'(cur.err));
        chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
        if (stall > 0) begin
          stall--;
          bus.rsp_ready = 1'b0;
        end else begin
          bus.rsp_ready = 1'b1;
          mon_have = 1'b0;
        end
      end else begin
        bus.rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'b000; bus.cmd_rd = 2'b00; bus.cmd_rs1 = 2'b00; bus.cmd_rs2 = 2'b00; bus.cmd_imm = 8'h00;
    model_reset();
    repeat (3) @(negedge clock);
    chk("reset_cmd_ready",  32'(bus.cmd_ready),  32'd1);
    chk("reset_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    chk("reset_alu_a",      32'(alu_a),          32'd0);
    chk("reset_alu_b",      32'(alu_b),          32'd0);
    chk("reset_alu_opcode", 32'(alu_opcode),     32'd0);
    chk("reset_rsp_data",   32'(bus.rsp_data),   32'd0);
    chk("reset_rsp_flags",  32'(bus.rsp_flags),  32'd0);
    chk("reset_rsp_err",    32'(bus.rsp_err),    32'd0);
    #1 reset_n = 1'b1;

    for (int i = 0; i < NREGS; i++) send(3'b101, 2'd0, 2'(i), 2'd0, 8'h00, 0);

    send(3'b100, 2'd0, 2'd0, 2'd0, 8'h7F, 0);
    send(3'b100, 2'd1, 2'd0, 2'd0, 8'h01, 0);
    send(3'b010, 2'd2, 2'd0, 2'd1, 8'h00, 0);
    send(3'b101, 2'd0, 2'd2, 2'd0, 8'h00, 0);
    send(3'b100, 2'd0, 2'd0, 2'd0, 8'h05, 0);
    send(3'b011, 2'd3, 2'd0, 2'd0, 8'h00, 0);

    send(3'b010, 2'd1, 2'd2, 2'd2, 8'h00, 5);
    send(3'b000, 2'd1, 2'd1, 2'd0, 8'h00, 0);
    send(3'b111, 2'd0, 2'd0, 2'd1, 8'hAA, 1);
    send(3'b101, 2'd0, 2'd0, 2'd0, 8'h00, 0);
    send(3'b110, 2'd2, 2'd0, 2'd1, 8'h00, 2);
    send(3'b101, 2'd0, 2'd2, 2'd0, 8'h00, 0);
    drain();

    // Reset asserted while an ADD sits in CAPTURE: command and response are dropped.
    @(negedge clock);
    bus.cmd_op = 3'b010; bus.cmd_rd = 2'd2; bus.cmd_rs1 = 2'd0; bus.cmd_rs2 = 2'd1; bus.cmd_valid = 1'b1;
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
    @(posedge clock);
    #2;
    chk("capture_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("midrst_alu_a",     32'(alu_a),         32'd0);
    chk("midrst_flags",     32'(bus.rsp_flags), 32'd0);
    @(negedge clock);
    @(negedge clock);
    #1 reset_n = 1'b1;
    send(3'b101, 2'd0, 2'd2, 2'd0, 8'h00, 0);

    for (int k = 0; k < 150; k++) begin
      send(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom),
           8'($urandom), $urandom_range(0, 2));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
